// File: rtl/buffer_read_ctrl.sv
// Pointer/occupancy controller for a circular word buffer: owns waddr/raddr and the fill count.
// It pops PAR_READ-word groups into a registered valid/ready output stage.
module buffer_read_ctrl #(
  parameter int NUM_BIT   = 4,
  parameter int DEPTH     = 5,
  parameter int ADDR_W    = 3,
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_commit,
  output logic                        wr_ready,
  output logic [ADDR_W-1:0]           waddr,
  output logic [ADDR_W-1:0]           raddr,
  input  logic [PAR_READ*NUM_BIT-1:0] rdata,
  output logic [PAR_READ*NUM_BIT-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W-1:0]           count,
  output logic                        full,
  output logic                        empty,
  output logic                        ovf
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PW_X    = (ADDR_W+1)'(PAR_WRITE);
  localparam logic [ADDR_W:0] PR_X    = (ADDR_W+1)'(PAR_READ);

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t          state, state_next;
  logic            load;
  logic            wr_acc;
  logic [ADDR_W:0] count_x;
  logic [ADDR_W:0] count_next;

  // Add one step in ADDR_W+1 bits so ptr+k never overflows before the wrap compare.
  function automatic logic [ADDR_W-1:0] ptr_adv(input logic [ADDR_W-1:0] ptr,
                                                input logic [ADDR_W:0]   k);
    logic [ADDR_W:0] sum;
    sum = {1'b0, ptr} + k;
    if (sum >= DEPTH_X) sum = sum - DEPTH_X;
    return sum[ADDR_W-1:0];
  endfunction

  assign count_x  = {1'b0, count};
  assign wr_ready = (count_x <= (DEPTH_X - PW_X));
  assign full     = (count_x == DEPTH_X);
  assign empty    = (count == '0);
  assign wr_acc   = wr_commit && wr_ready && !flush;
  // Registered count only: a word written at this edge becomes poppable one edge later.
  assign load     = (count_x >= PR_X) && (!out_valid || out_ready);

  always_comb begin
    count_next = count_x + (wr_acc ? PW_X : '0) - (load ? PR_X : '0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) state <= S_EMPTY;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: if (load) state_next = S_HOLD;
      S_HOLD:  if (!load && out_ready) state_next = S_EMPTY;
      default: state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr    <= '0;
      raddr    <= '0;
      count    <= '0;
      out_data <= '0;
      ovf      <= 1'b0;
    end else if (flush) begin
      waddr    <= '0;
      raddr    <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      if (wr_acc) waddr <= ptr_adv(waddr, PW_X);
      if (wr_commit && !wr_ready) ovf <= 1'b1;
      if (load) begin
        raddr    <= ptr_adv(raddr, PR_X);
        out_data <= rdata;
      end
      count <= count_next[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_buffer_read_ctrl.sv
// Directed-vector bench for buffer_read_ctrl with a behavioural word buffer and an output scoreboard.
module tb_buffer_read_ctrl;

  localparam int NB = 4;
  localparam int D  = 5;
  localparam int AW = 3;
  localparam int PW = 2;
  localparam int PR = 1;
  localparam int NV = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           wr_commit = 1'b0;
  logic           out_ready = 1'b0;
  logic [PW*NB-1:0] wdat = '0;
  logic           wr_ready, out_valid, full, empty, ovf;
  logic [AW-1:0]  waddr, raddr, count;
  logic [PR*NB-1:0] rdata, out_data;
  logic [NB-1:0]  mem [D];

  int checks = 0;
  int errors = 0;

  buffer_read_ctrl #(.NUM_BIT(NB), .DEPTH(D), .ADDR_W(AW), .PAR_WRITE(PW), .PAR_READ(PR)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_commit(wr_commit), .wr_ready(wr_ready),
    .waddr(waddr), .raddr(raddr), .rdata(rdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .full(full), .empty(empty), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Behavioural buffer: parallel write at waddr, combinational parallel read at raddr.
  always @(posedge clk) begin
    if (!rst && !flush && wr_commit && wr_ready)
      for (int i = 0; i < PW; i++) mem[(int'(waddr) + i) % D] <= wdat[i*NB +: NB];
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < PR; i++) rdata[i*NB +: NB] = mem[(int'(raddr) + i) % D];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, flush, wc;
    logic [7:0] wd;
    logic       ord;
    logic [2:0] e_wa, e_ra, e_cnt;
    logic       e_vld;
    logic [3:0] e_dat;
    logic       e_wrr, e_full, e_emp, e_ovf;
  } vec_t;

  vec_t v [NV];

  // Scoreboard: words leave in exactly the order they were committed.
  logic          mon_en = 1'b0;
  logic [NB-1:0] exp_q [$];
  int            pushed = 0;
  int            popped = 0;
  logic          prev_stall = 1'b0;
  logic [PR*NB-1:0] prev_dat = '0;
  logic [NB-1:0] next_word = '0;
  int            model_wa = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_dat);
      end
      if (out_valid && out_ready) begin
        for (int i = 0; i < PR; i++) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_extra: got word %0h expected no word", out_data[i*NB +: NB]);
          end else begin
            chk("pop_word", out_data[i*NB +: NB], exp_q.pop_front());
          end
          popped++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
    end
  end

  task automatic stream(input int ncommit, input bit rand_rdy, input int budget);
    int done = 0;
    int cyc = 0;
    bit acc;
    while (done < ncommit && cyc < budget) begin
      acc = wr_ready && (!rand_rdy || $urandom_range(0, 3) != 0);
      wr_commit = acc;
      if (acc) begin
        for (int i = 0; i < PW; i++) begin
          wdat[i*NB +: NB] = next_word;
          exp_q.push_back(next_word);
          next_word = next_word + 1'b1;
          pushed++;
        end
      end
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        model_wa = (model_wa + PW) % D;
        chk($sformatf("waddr_seq%0d", done), waddr, model_wa);
        done++;
      end
    end
    wr_commit = 1'b0;
    if (done < ncommit) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d commits expected %0d", done, ncommit);
    end
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    out_ready = 1'b1;
    wr_commit = 1'b0;
    while ((out_valid || !empty) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_done", out_valid || !empty, 0);
    chk("pop_total", popped, pushed);
    chk("queue_left", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = '0;
    //        rst   flush wc    wd     ord   | wa    ra    cnt   vld   dat   wrr   full  emp   ovf
    v[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    v[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    v[2]  = '{1'b0, 1'b0, 1'b1, 8'h73, 1'b1, 3'd2, 3'd0, 3'd2, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 3'd1, 3'd1, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0};
    v[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd0, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0};
    v[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0};
    v[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    v[7]  = '{1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 3'd2, 3'd0, 3'd2, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[8]  = '{1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 3'd4, 3'd1, 3'd3, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0};
    v[9]  = '{1'b0, 1'b0, 1'b1, 8'h65, 1'b0, 3'd1, 3'd1, 3'd5, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0};
    v[10] = '{1'b0, 1'b0, 1'b1, 8'h87, 1'b0, 3'd1, 3'd1, 3'd5, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1};
    v[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 3'd1, 3'd5, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1};
    v[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 3'd2, 3'd4, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1};
    v[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 3'd3, 3'd3, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1};
    v[14] = '{1'b0, 1'b1, 1'b1, 8'ha9, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1};
    v[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < NV; i++) begin
      rst = v[i].rst;
      flush = v[i].flush;
      wr_commit = v[i].wc;
      wdat = v[i].wd;
      out_ready = v[i].ord;
      @(posedge clk); #1;
      chk($sformatf("v%0d_waddr", i), waddr, v[i].e_wa);
      chk($sformatf("v%0d_raddr", i), raddr, v[i].e_ra);
      chk($sformatf("v%0d_count", i), count, v[i].e_cnt);
      chk($sformatf("v%0d_out_valid", i), out_valid, v[i].e_vld);
      chk($sformatf("v%0d_out_data", i), out_data, v[i].e_dat);
      chk($sformatf("v%0d_wr_ready", i), wr_ready, v[i].e_wrr);
      chk($sformatf("v%0d_full", i), full, v[i].e_full);
      chk($sformatf("v%0d_empty", i), empty, v[i].e_emp);
      chk($sformatf("v%0d_ovf", i), ovf, v[i].e_ovf);
    end

    rst = 1'b1;
    flush = 1'b0;
    wr_commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_wa = 0;
    mon_en = 1'b1;

    // Wrap: ten commits with a free-running consumer.
    stream(10, 1'b0, 200);
    drain(50);

    // Random back-pressure while streaming.
    stream(40, 1'b1, 2000);
    drain(100);
    chk("final_ovf", ovf, 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
